// File: rtl/pipelined_adder_tree_if.sv
// Streaming bus for the pipelined adder tree: one vector per cycle in, one
// reduced (or accumulated) result out, no backpressure.
interface pipelined_adder_tree_if #(
    parameter int N         = 8,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(N),
    parameter int CNT_WIDTH = 16
);
    logic                 valid_in;
    logic [IN_WIDTH-1:0]  vector_in [N];
    logic                 acc_en;
    logic                 last_in;
    logic                 valid_out;
    logic [OUT_WIDTH-1:0] sum_out;
    logic [CNT_WIDTH-1:0] count_out;
    logic                 overflow_out;

    modport master (
        output valid_in, vector_in, acc_en, last_in,
        input  valid_out, sum_out, count_out, overflow_out
    );

    modport slave (
        input  valid_in, vector_in, acc_en, last_in,
        output valid_out, sum_out, count_out, overflow_out
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined N-lane reduction tree with an optional multi-vector
// accumulator that closes on last_in and reports count and sticky overflow.
module pipelined_adder_tree #(
    parameter int N         = 8,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(N),
    parameter bit SIGNED    = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    pipelined_adder_tree_if.slave bus
);

    // Number of nodes on tree level l (level 0 = extended input lanes).
    function automatic int lvl_cnt(input int l);
        int c;
        c = N;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    // Index of the first node of level l in the flat node array.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += lvl_cnt(k);
        return o;
    endfunction

    localparam int L         = (N > 1) ? $clog2(N) : 0;
    localparam int NODES     = lvl_off(L + 1);
    localparam int REG_NODES = (NODES > N) ? NODES - N : 1;

    // Flat view of every level: extended lanes first, then registered levels.
    logic [OUT_WIDTH-1:0] node   [NODES];
    logic [OUT_WIDTH-1:0] tree_d [REG_NODES];
    logic [OUT_WIDTH-1:0] tree_q [REG_NODES];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (SIGNED) node[i] = OUT_WIDTH'($signed(bus.vector_in[i]));
            else        node[i] = OUT_WIDTH'(bus.vector_in[i]);
        end
        for (int i = N; i < NODES; i++) node[i] = tree_q[i - N];
    end

    // Pairs (2j, 2j+1) add; an odd trailing node passes through unchanged.
    always_comb begin
        for (int r = 0; r < REG_NODES; r++) tree_d[r] = '0;
        for (int l = 1; l <= L; l++) begin
            for (int j = 0; j < lvl_cnt(l); j++) begin
                if (2 * j + 1 < lvl_cnt(l - 1))
                    tree_d[lvl_off(l) - N + j] = node[lvl_off(l - 1) + 2 * j]
                                               + node[lvl_off(l - 1) + 2 * j + 1];
                else
                    tree_d[lvl_off(l) - N + j] = node[lvl_off(l - 1) + 2 * j];
            end
        end
    end

    // NOTE: tree data carries no reset; only the valid tags decide whether it
    // is ever consumed, so clearing it would just add reset fanout.
    always_ff @(posedge clk) begin
        tree_q <= tree_d;
    end

    logic s_vld;
    logic s_acc;
    logic s_last;

    if (L > 0) begin : g_ctl
        logic [L-1:0] vld_sr_q;
        logic [L-1:0] acc_sr_q;
        logic [L-1:0] last_sr_q;

        // NOTE: state updates use <= so every stage samples the previous
        // stage's value from before the clock edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_sr_q <= '0;
            end else begin
                vld_sr_q[0] <= bus.valid_in;
                for (int i = 1; i < L; i++) vld_sr_q[i] <= vld_sr_q[i-1];
            end
            acc_sr_q[0]  <= bus.acc_en;
            last_sr_q[0] <= bus.last_in;
            for (int i = 1; i < L; i++) begin
                acc_sr_q[i]  <= acc_sr_q[i-1];
                last_sr_q[i] <= last_sr_q[i-1];
            end
        end

        assign s_vld  = vld_sr_q[L-1];
        assign s_acc  = acc_sr_q[L-1];
        assign s_last = last_sr_q[L-1];
    end else begin : g_ctl_bypass
        assign s_vld  = bus.valid_in;
        assign s_acc  = bus.acc_en;
        assign s_last = bus.last_in;
    end

    logic [OUT_WIDTH-1:0] tree_sum;
    logic [OUT_WIDTH:0]   acc_sum_full;
    logic [OUT_WIDTH-1:0] acc_sum;
    logic                 add_ovf;
    logic [CNT_WIDTH-1:0] cnt_inc;

    logic [OUT_WIDTH-1:0] acc_d, acc_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 ovf_d, ovf_q;
    logic                 valid_d, valid_q;
    logic [OUT_WIDTH-1:0] sum_d, sum_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 ovf_out_d, ovf_out_q;

    assign tree_sum     = node[NODES-1];
    assign acc_sum_full = {1'b0, acc_q} + {1'b0, tree_sum};
    assign acc_sum      = acc_sum_full[OUT_WIDTH-1:0];
    assign add_ovf      = SIGNED ? ((acc_q[OUT_WIDTH-1] == tree_sum[OUT_WIDTH-1]) &&
                                    (acc_sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]))
                                 : acc_sum_full[OUT_WIDTH];
    assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        sum_d     = sum_q;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;
        if (s_vld) begin
            if (!s_acc) begin
                valid_d   = 1'b1;
                sum_d     = tree_sum;
                count_d   = CNT_WIDTH'(1);
                ovf_out_d = 1'b0;
            end else if (!s_last) begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | add_ovf;
            end else begin
                valid_d   = 1'b1;
                sum_d     = acc_sum;
                count_d   = cnt_inc;
                ovf_out_d = ovf_q | add_ovf;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign bus.valid_out    = valid_q;
    assign bus.sum_out      = sum_q;
    assign bus.count_out    = count_q;
    assign bus.overflow_out = ovf_out_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: N=8 and N=5 instances (IN=8, OUT=11, signed)
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_pipelined_adder_tree;

    localparam int IW = 8;
    localparam int OW = 11;
    localparam int CW = 16;

    typedef struct {
        int            due;
        logic [OW-1:0] sum;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_adder_tree_if #(.N(8), .IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) if8 ();
    pipelined_adder_tree_if #(.N(5), .IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) if5 ();

    pipelined_adder_tree #(.N(8), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(1'b1), .CNT_WIDTH(CW))
        u_dut8 (.clk(clk), .reset(reset), .bus(if8));
    pipelined_adder_tree #(.N(5), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(1'b1), .CNT_WIDTH(CW))
        u_dut5 (.clk(clk), .reset(reset), .bus(if5));

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    int   rst_at   = -1;
    exp_t q8[$];
    exp_t q5[$];
    exp_t h8, h5;
    int   m_acc[2];
    int   m_cnt[2];
    bit   m_ovf[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int wrap_ow(input int x);
        int w;
        w = x & ((1 << OW) - 1);
        if (w >= (1 << (OW - 1))) w -= (1 << OW);
        return w;
    endfunction

    // Result rules in plain integer arithmetic; overflow means the exact sum
    // left the signed OW-bit range.
    task automatic model(input int id, input int s_true, input bit a, input bit l, input int due);
        exp_t e;
        int   s, t, w;
        s     = wrap_ow(s_true);
        e.due = due;
        if (!a) begin
            e.sum = OW'(s);
            e.cnt = CW'(1);
            e.ovf = 1'b0;
            if (id == 0) q8.push_back(e); else q5.push_back(e);
        end else begin
            t         = m_acc[id] + s;
            w         = wrap_ow(t);
            m_ovf[id] = m_ovf[id] | (t != w);
            m_cnt[id] = (m_cnt[id] == 65535) ? 65535 : m_cnt[id] + 1;
            m_acc[id] = w;
            if (l) begin
                e.sum = OW'(w);
                e.cnt = CW'(m_cnt[id]);
                e.ovf = m_ovf[id];
                if (id == 0) q8.push_back(e); else q5.push_back(e);
                m_acc[id] = 0;
                m_cnt[id] = 0;
                m_ovf[id] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if8.valid_in = 1'b0; if8.acc_en = 1'b0; if8.last_in = 1'b0;
        if5.valid_in = 1'b0; if5.acc_en = 1'b0; if5.last_in = 1'b0;
    endtask

    task automatic put8(input int v[8], input bit a, input bit l);
        int s;
        s = 0;
        if8.valid_in = 1'b1;
        if8.acc_en   = a;
        if8.last_in  = l;
        for (int k = 0; k < 8; k++) begin
            if8.vector_in[k] = v[k][IW-1:0];
            s += v[k];
        end
        model(0, s, a, l, cyc + 4);
    endtask

    task automatic put5(input int v[5], input bit a, input bit l);
        int s;
        s = 0;
        if5.valid_in = 1'b1;
        if5.acc_en   = a;
        if5.last_in  = l;
        for (int k = 0; k < 5; k++) begin
            if5.vector_in[k] = v[k][IW-1:0];
            s += v[k];
        end
        model(1, s, a, l, cyc + 4);
    endtask

    task automatic cmp(input int id);
        logic          v, o;
        logic [OW-1:0] s;
        logic [CW-1:0] c;
        exp_t          e;
        bit            due_now;
        string         p;
        if (id == 0) begin
            v = if8.valid_out; s = if8.sum_out; c = if8.count_out; o = if8.overflow_out;
            due_now = (q8.size() > 0) && (q8[0].due == cyc);
            if (due_now) e = q8.pop_front(); else e = h8;
            p = "n8";
        end else begin
            v = if5.valid_out; s = if5.sum_out; c = if5.count_out; o = if5.overflow_out;
            due_now = (q5.size() > 0) && (q5[0].due == cyc);
            if (due_now) e = q5.pop_front(); else e = h5;
            p = "n5";
        end
        check({p, " valid_out"}, 32'(v), 32'(due_now));
        check({p, " sum_out"}, 32'(s), 32'(e.sum));
        check({p, " count_out"}, 32'(c), 32'(e.cnt));
        check({p, " overflow_out"}, 32'(o), 32'(e.ovf));
        if (due_now) begin
            if (id == 0) h8 = e; else h5 = e;
        end
    endtask

    // Outputs hold between results; reset zeroes them one edge after assertion.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_at) begin
                h8.sum = '0; h8.cnt = '0; h8.ovf = 1'b0;
                h5.sum = '0; h5.cnt = '0; h5.ovf = 1'b0;
            end
            cmp(0);
            cmp(1);
        end
    end

    task automatic hand(input int id, input int due, input logic [OW-1:0] s, input int c,
                        input bit o, input string nm);
        while (cyc < due) @(negedge clk);
        if (id == 0) begin
            check({nm, " valid"}, 32'(if8.valid_out), 32'(1));
            check({nm, " sum"}, 32'(if8.sum_out), 32'(s));
            check({nm, " count"}, 32'(if8.count_out), 32'(c));
            check({nm, " ovf"}, 32'(if8.overflow_out), 32'(o));
        end else begin
            check({nm, " valid"}, 32'(if5.valid_out), 32'(1));
            check({nm, " sum"}, 32'(if5.sum_out), 32'(s));
            check({nm, " count"}, 32'(if5.count_out), 32'(c));
            check({nm, " ovf"}, 32'(if5.overflow_out), 32'(o));
        end
    endtask

    task automatic reset_mid_run();
        tick();
        reset = 1'b1;
        if8.valid_in = 1'b1; if8.acc_en = 1'b1; if8.last_in = 1'b1;
        for (int k = 0; k < 8; k++) if8.vector_in[k] = 8'd9;
        while (q8.size() > 0 && q8[$].due > cyc) void'(q8.pop_back());
        while (q5.size() > 0 && q5[$].due > cyc) void'(q5.pop_back());
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
        rst_at = cyc + 1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v8[8];
        int v5[5];
        int d8;

        h8 = '{0, '0, '0, 1'b0};
        h5 = '{0, '0, '0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
        reset = 1'b1;
        if8.valid_in = 1'b0; if8.acc_en = 1'b0; if8.last_in = 1'b0;
        if5.valid_in = 1'b0; if5.acc_en = 1'b0; if5.last_in = 1'b0;
        for (int k = 0; k < 8; k++) if8.vector_in[k] = '0;
        for (int k = 0; k < 5; k++) if5.vector_in[k] = '0;

        // valid_in held high through reset must never surface.
        repeat (3) begin
            tick();
            if8.valid_in = 1'b1;
            if5.valid_in = 1'b1;
        end
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset sum8", 32'(if8.sum_out), 32'(0));
        check("reset count8", 32'(if8.count_out), 32'(0));
        check("reset valid5", 32'(if5.valid_out), 32'(0));

        // Single pass-through vectors.
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 127;
        put8(v8, 1'b0, 1'b0);
        d8 = cyc + 4;
        tick();
        hand(0, d8, 11'd1016, 1, 1'b0, "all_max");

        tick();
        for (int k = 0; k < 8; k++) v8[k] = -128;
        for (int k = 0; k < 5; k++) v5[k] = k + 1;
        put8(v8, 1'b0, 1'b0);
        put5(v5, 1'b0, 1'b0);
        d8 = cyc + 4;
        tick();
        hand(0, d8, 11'h400, 1, 1'b0, "all_min");
        hand(1, d8, 11'd15, 1, 1'b0, "n5_ramp");

        // Three-vector group.
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int k = 0; k < 8; k++) v8[k] = 1;
            put8(v8, 1'b1, i == 2);
            d8 = cyc + 4;
        end
        tick();
        hand(0, d8, 11'd24, 3, 1'b0, "acc3");

        // Overflowing group, then a clean one.
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int k = 0; k < 8; k++) v8[k] = 127;
            put8(v8, 1'b1, i == 1);
            d8 = cyc + 4;
        end
        tick();
        hand(0, d8, 11'h7F0, 2, 1'b1, "acc_ovf");
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 1;
        put8(v8, 1'b1, 1'b1);
        d8 = cyc + 4;
        tick();
        hand(0, d8, 11'd8, 1, 1'b0, "acc_clean");

        // Back-to-back stream on both instances.
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int k = 0; k < 8; k++) v8[k] = i + k;
            for (int k = 0; k < 5; k++) v5[k] = 7 * k - 5 * i;
            put8(v8, 1'b0, 1'b0);
            put5(v5, 1'b0, 1'b0);
        end

        // Pass-through vector inside an open group.
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 2;
        put8(v8, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 3;
        put8(v8, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 1;
        put8(v8, 1'b1, 1'b1);
        d8 = cyc + 4;
        tick();
        hand(0, d8, 11'd24, 2, 1'b0, "interleave_grp");

        // Reset in the middle of an open group.
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int k = 0; k < 8; k++) v8[k] = 5;
            put8(v8, 1'b1, 1'b0);
        end
        reset_mid_run();
        @(negedge clk);
        check("mid_reset sum8", 32'(if8.sum_out), 32'(0));
        check("mid_reset count8", 32'(if8.count_out), 32'(0));
        tick();
        for (int k = 0; k < 8; k++) v8[k] = 2;
        put8(v8, 1'b1, 1'b1);
        d8 = cyc + 4;
        tick();
        hand(0, d8, 11'd16, 1, 1'b0, "post_reset");

        repeat (8) tick();
        check("n8 queue drained", 32'(q8.size()), 32'(0));
        check("n5 queue drained", 32'(q5.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
